// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1/8N2 UART serialiser with one-entry holding buffer
module uart_transmitter #(
    parameter logic [15:0] BIT_RATE_VAL = 16'h01B0,
    parameter int          STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       res,
    input  logic       send,
    input  logic [7:0] din,
    output logic       ready,
    output logic       tx,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Counter reload gives BIT_RATE_VAL+3 cycles per bit (reload value down to 0 inclusive)
    localparam logic [15:0] RELOAD    = BIT_RATE_VAL + 16'd2;
    localparam logic        LAST_STOP = (STOP_BITS == 2);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic [7:0]  shift_q;
    logic [7:0]  hold_q;
    logic        hold_full;

    logic bit_end;
    logic last_stop_bit;
    logic frame_end;
    logic accept;

    assign bit_end       = (cnt == 16'd0);
    assign last_stop_bit = (state == STOP) && (stop_idx == LAST_STOP);
    assign frame_end     = last_stop_bit && bit_end;
    // Only blocked when a frame is running and a second byte is already waiting
    assign ready         = (state == IDLE) || !hold_full;
    assign accept        = send && ready;

    // Frame sequencer, bit timer, shifter and holding buffer
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            bit_idx   <= 3'd0;
            stop_idx  <= 1'b0;
            shift_q   <= 8'd0;
            hold_q    <= 8'd0;
            hold_full <= 1'b0;
            tx        <= 1'b1;
            done      <= 1'b0;
        end else begin
            // Raised on the edge that brings the final stop bit's counter to 0,
            // so it is high exactly during the last clk of the frame
            done <= last_stop_bit && (cnt == 16'd1);

            // A byte arriving mid-frame parks in the buffer; at frame end it goes straight to the shifter
            if (accept && (state != IDLE) && !frame_end) begin
                hold_q    <= din;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (accept) begin
                        shift_q <= din;
                        tx      <= 1'b0;
                        cnt     <= RELOAD;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shift_q[0];
                        bit_idx <= 3'd0;
                        cnt     <= RELOAD;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx       <= 1'b1;
                            stop_idx <= 1'b0;
                            state    <= STOP;
                        end else begin
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx      <= shift_q[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_idx == LAST_STOP) begin
                            if (hold_full) begin
                                shift_q   <= hold_q;
                                hold_full <= 1'b0;
                                tx        <= 1'b0;
                                cnt       <= RELOAD;
                                state     <= START;
                            end else if (accept) begin
                                shift_q <= din;
                                tx      <= 1'b0;
                                cnt     <= RELOAD;
                                state   <= START;
                            end else begin
                                tx    <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            cnt      <= RELOAD;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

    localparam int P = 435;

    logic       clk;
    logic       res;
    logic       send;
    logic [7:0] din;
    logic       ready;
    logic       tx;
    logic       done;

    logic       send2;
    logic [7:0] din2;
    logic       ready2;
    logic       tx2;
    logic       done2;

    int checks = 0;
    int errors = 0;

    uart_transmitter u_dut (
        .clk   (clk),
        .res   (res),
        .send  (send),
        .din   (din),
        .ready (ready),
        .tx    (tx),
        .done  (done)
    );

    uart_transmitter #(
        .BIT_RATE_VAL (16'h0000),
        .STOP_BITS    (2)
    ) u_dut2 (
        .clk   (clk),
        .res   (res),
        .send  (send2),
        .din   (din2),
        .ready (ready2),
        .tx    (tx2),
        .done  (done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Loopback receiver: samples the middle of each bit of the default-rate line
    logic [7:0] rx_q[$];
    logic [7:0] rx_sh;
    int         rx_ferr = 0;
    bit         rx_busy = 0;
    int         rx_t = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (res) begin
            rx_busy = 0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % P == P / 2) begin
                if (rx_t / P == 0) begin
                    if (tx !== 1'b0) rx_busy = 0;
                end else if (rx_t / P <= 8) begin
                    rx_sh[rx_t / P - 1] = tx;
                end else begin
                    if (tx === 1'b1) rx_q.push_back(rx_sh);
                    else rx_ferr++;
                    rx_busy = 0;
                end
            end
        end
    end

    task automatic test_reset();
        int edges;
        logic last;
        res = 1'b1; send = 1'b0; din = 8'h00; send2 = 1'b0; din2 = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b ready=%b done=%b, required 1 1 0", tx, ready, done);
        end
        res = 1'b0;
        edges = 0;
        last = tx;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx !== last) edges++;
            last = tx;
        end
        checks++;
        if (edges != 0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_line: %0d tx edges, tx=%b, required 0 edges and tx=1", edges, tx);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b = 8'hA5;
        logic [9:0] bad = '0;
        logic [9:0] bad_val = '0;
        logic       exp;
        int         k, done_hits = 0, done_idx = -1, qs;
        rx_q.delete();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready_before: ready=%b, required 1", ready);
        end
        send = 1'b1; din = b;
        for (int idx = 1; idx <= 4351; idx++) begin
            @(negedge clk);
            if (idx == 1) send = 1'b0;
            if (done === 1'b1) begin done_hits++; done_idx = idx; end
            if (idx <= 4350) begin
                k = (idx - 1) / P;
                exp = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
                if (tx !== exp && !bad[k]) begin bad[k] = 1'b1; bad_val[k] = tx; end
            end
        end
        for (int j = 0; j < 10; j++) begin
            checks++;
            if (bad[j]) begin
                errors++;
                $display("FAIL single_bit%0d: tx=%b seen, required %b for all %0d cycles", j, bad_val[j],
                         (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : 1'b1, P);
            end
        end
        checks++;
        if (done_hits != 1 || done_idx != 4350) begin
            errors++;
            $display("FAIL single_done: %0d pulses, last at accept+%0d, required 1 at accept+4350", done_hits, done_idx);
        end
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL single_after: tx=%b ready=%b, required 1 1", tx, ready);
        end
        qs = rx_q.size();
        checks++;
        if (qs != 1 || rx_q[0] !== 8'hA5 || rx_ferr != 0) begin
            errors++;
            $display("FAIL single_loopback: %0d bytes first=%h ferr=%0d, required 1 byte a5", qs,
                     (qs > 0) ? rx_q[0] : 8'h00, rx_ferr);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        int  k = 0, t = 0, nd = 0;
        int  done_t [3];
        bit  acc_prev, prev_done = 0;
        rx_q.delete();
        @(negedge clk);
        send = 1'b1; din = bytes[0];
        acc_prev = (ready === 1'b1);
        while (nd < 3 && t < 15000) begin
            @(negedge clk);
            t++;
            if (prev_done && nd < 3) begin
                checks++;
                if (tx !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_contiguous%0d: tx=%b after done, required 0", nd, tx);
                end
            end
            prev_done = 0;
            if (acc_prev) begin
                k++;
                if (k < 3) din = bytes[k];
                else send = 1'b0;
                if (k == 2) begin
                    checks++;
                    if (ready !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_ready_drop: ready=%b after 2nd accept, required 0", ready);
                    end
                end
            end
            acc_prev = send && (ready === 1'b1);
            if (done === 1'b1) begin
                done_t[nd] = t;
                nd++;
                prev_done = 1;
            end
        end
        send = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (nd != 3) begin
            errors++;
            $display("FAIL b2b_done_count: %0d done pulses, required 3", nd);
        end else begin
            checks++;
            if (done_t[1] - done_t[0] != 4350 || done_t[2] - done_t[1] != 4350) begin
                errors++;
                $display("FAIL b2b_spacing: %0d and %0d cycles, required 4350", done_t[1] - done_t[0],
                         done_t[2] - done_t[1]);
            end
        end
        checks++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'hFF || rx_q[2] !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_loopback: %0d bytes received, required 00 ff 3c", rx_q.size());
        end
    endtask

    task automatic test_two_stop_fast();
        logic [7:0]  b = 8'h81;
        logic [10:0] bad = '0;
        logic        exp;
        int          k, done_hits = 0, done_idx = -1;
        @(negedge clk);
        send2 = 1'b1; din2 = b;
        for (int idx = 1; idx <= 34; idx++) begin
            @(negedge clk);
            if (idx == 1) send2 = 1'b0;
            if (done2 === 1'b1) begin done_hits++; done_idx = idx; end
            if (idx <= 33) begin
                k = (idx - 1) / 3;
                exp = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
                if (tx2 !== exp) bad[k] = 1'b1;
            end
        end
        for (int j = 0; j < 11; j++) begin
            checks++;
            if (bad[j]) begin
                errors++;
                $display("FAIL fast_bit%0d: tx2 wrong level in bit, required %b", j,
                         (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : 1'b1);
            end
        end
        checks++;
        if (done_hits != 1 || done_idx != 33) begin
            errors++;
            $display("FAIL fast_done: %0d pulses at %0d, required 1 at 33", done_hits, done_idx);
        end
        checks++;
        if (tx2 !== 1'b1 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL fast_after: tx2=%b ready2=%b, required 1 1", tx2, ready2);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, edges = 0, t = 0;
        rx_q.delete();
        @(negedge clk);
        send = 1'b1; din = 8'h0F;
        @(negedge clk);
        din = 8'h33;
        @(negedge clk);
        send = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_buffer_full: ready=%b, required 0", ready);
        end
        // advance into data bit 4 (frame bit 5)
        repeat (5 * P + 100 - 2) @(negedge clk);
        d0 = done_cnt;
        res = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: tx=%b ready=%b done=%b, required 1 1 0", tx, ready, done);
        end
        @(negedge clk);
        res = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) edges++;
        end
        checks++;
        if (done_cnt != d0 || edges != 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: %0d done pulses, %0d low cycles, required 0 0", done_cnt - d0, edges);
        end
        send = 1'b1; din = 8'h5A;
        @(negedge clk);
        send = 1'b0;
        while (done_cnt == d0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            errors++;
            $display("FAIL rst_mid_next_byte: %0d done, %0d bytes, required 1 done and byte 5a",
                     done_cnt - d0, rx_q.size());
        end
    endtask

    task automatic test_send_while_busy();
        int d0, t = 0;
        rx_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        send = 1'b1; din = 8'h11;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        din = 8'hEE;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready_low: ready=%b, required 0", ready);
        end
        while (ready !== 1'b1 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        send = 1'b0;
        t = 0;
        while (done_cnt - d0 < 2 && t < 10000) begin
            @(negedge clk);
            t++;
        end
        repeat (3000) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 2 || rx_q.size() != 2 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_ferr != 0) begin
            errors++;
            $display("FAIL busy_ignored: %0d done, %0d bytes, ferr=%0d, required 2 done and bytes 11 22",
                     done_cnt - d0, rx_q.size(), rx_ferr);
        end
        checks++;
        if (tx !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL busy_final_idle: tx=%b ready=%b, required 1 1", tx, ready);
        end
    endtask

    initial begin
        res = 1'b1; send = 1'b0; din = 8'h00; send2 = 1'b0; din2 = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_two_stop_fast();
        test_reset_mid_frame();
        test_send_while_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
